// File: rtl/align_fifo_if.sv
// Push/pop bus for align_fifo: entry-side push, result-side pop, occupancy and sticky error flags.
// Handshake: push and pop are one-cycle strobes with no ready; acceptance is reported only via count/flags and pop_valid.
interface align_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, push_data, pop,
    input  pop_data, pop_valid, count, full, empty, overflow, underflow
  );

  modport slave (
    input  push, push_data, pop,
    output pop_data, pop_valid, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/align_fifo.sv
// Latency-matching sideband FIFO: tags pushed at pipeline entry, released in order on result-valid.
// Optional ALIGN_FIFO_BYPASS_EN: a push and pop into an empty FIFO pass straight through to pop_data.
module align_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  align_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic             overflow;
  logic             underflow;
  logic             full;
  logic             empty;
  logic             pop_acc;
  logic             push_acc;
  logic             bypass;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

`ifdef ALIGN_FIFO_BYPASS_EN
  assign bypass = empty && bus.push && bus.pop;
`else
  assign bypass = 1'b0;
`endif

  // Pop acceptance uses pre-cycle occupancy, so a full FIFO can take a push alongside a pop.
  assign pop_acc  = bus.pop && !empty;
  assign push_acc = bus.push && !bypass && (!full || pop_acc);

  // Storage is not reset; a same-cycle write to the slot being read returns the old entry.
  always_ff @(posedge clk) begin
    if (!reset && push_acc) mem[wp] <= bus.push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= pop_acc || bypass;
      if (pop_acc) begin
        pop_data <= mem[rp];
        rp       <= rp + AW'(1);
      end else if (bypass) begin
        pop_data <= bus.push_data;
      end
      if (push_acc) wp <= wp + AW'(1);
      case ({push_acc, pop_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.push && !push_acc && !bypass) overflow  <= 1'b1;
      if (bus.pop && !pop_acc && !bypass)   underflow <= 1'b1;
    end
  end

  assign bus.pop_data  = pop_data;
  assign bus.pop_valid = pop_valid;
  assign bus.count     = count;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
endmodule

// File: tb/tb_align_fifo.sv
// Self-checking bench for align_fifo: queue model of stored entries plus an expected-output scoreboard.
module tb_align_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk;
  logic reset;

  align_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  align_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] model_q[$];
  logic             m_over;
  logic             m_under;
  int               n_cmp;
  int               n_err;

  // scoreboard: every pop_valid must match the head of the expected queue
  always @(negedge clk) begin
    if (bus.pop_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: pop_valid with data %h, no output expected", bus.pop_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (bus.pop_data !== e) begin
          n_err++;
          $display("FAIL sb_data: got %h, expected %h", bus.pop_data, e);
        end
      end
    end
  end

  // driver: one clock of stimulus, with the model updated from pre-edge state
  task automatic cycle(input logic p, input logic [WIDTH-1:0] d, input logic q);
    bit pop_ok, push_ok, byp;
    bus.push      = p;
    bus.push_data = d;
    bus.pop       = q;
    byp = 1'b0;
`ifdef ALIGN_FIFO_BYPASS_EN
    byp = p && q && (model_q.size() == 0);
`endif
    pop_ok  = q && (model_q.size() != 0);
    push_ok = p && !byp && ((model_q.size() < DEPTH) || pop_ok);
    if (byp) exp_q.push_back(d);
    if (pop_ok) exp_q.push_back(model_q.pop_front());
    if (push_ok) model_q.push_back(d);
    if (p && !push_ok && !byp) m_over = 1'b1;
    if (q && !pop_ok && !byp) m_under = 1'b1;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic apply_reset(input logic q);
    reset   = 1'b1;
    bus.pop = q;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    bus.pop = 1'b0;
    model_q.delete();
    exp_q.delete();
    m_over  = 1'b0;
    m_under = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.pop_data, bus.pop_valid, bus.count, bus.empty, bus.full, bus.overflow, bus.underflow}
        !== {{WIDTH{1'b0}}, 1'b0, {CW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: data=%h v=%b cnt=%0d e=%b f=%b ov=%b un=%b, want 0 0 0 1 0 0 0",
               bus.pop_data, bus.pop_valid, bus.count, bus.empty, bus.full, bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, vals[i], 1'b0);
      n_cmp++;
      if (bus.count !== CW'(i + 1)) begin
        n_err++;
        $display("FAIL basic_fill_count: got %0d, expected %0d", bus.count, i + 1);
      end
    end
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1);
      n_cmp++;
      if (bus.pop_valid !== 1'b1 || bus.pop_data !== vals[i] || bus.count !== CW'(2 - i)) begin
        n_err++;
        $display("FAIL basic_drain: v=%b data=%h cnt=%0d, expected 1 %h %0d",
                 bus.pop_valid, bus.pop_data, bus.count, vals[i], 2 - i);
      end
    end
    cycle(1'b0, '0, 1'b0);
    n_cmp++;
    if (bus.empty !== 1'b1 || bus.pop_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_end: empty=%b pop_valid=%b, expected 1 0", bus.empty, bus.pop_valid);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(i), 1'b0);
    n_cmp++;
    if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_full: full=%b overflow=%b, expected 1 0", bus.full, bus.overflow);
    end
    cycle(1'b1, 8'hAA, 1'b0);
    n_cmp++;
    if (bus.full !== 1'b1 || bus.overflow !== 1'b1 || bus.count !== CW'(DEPTH)) begin
      n_err++;
      $display("FAIL ovf_reject: full=%b overflow=%b cnt=%0d, expected 1 1 %0d",
               bus.full, bus.overflow, bus.count, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    n_cmp++;
    if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_drained: empty=%b overflow=%b, expected 1 1", bus.empty, bus.overflow);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(i), 1'b0);
    cycle(1'b1, 8'h55, 1'b1);
    n_cmp++;
    if (bus.pop_data !== 8'h00 || bus.pop_valid !== 1'b1 || bus.count !== CW'(DEPTH)) begin
      n_err++;
      $display("FAIL full_pp: data=%h v=%b cnt=%0d, expected 00 1 %0d",
               bus.pop_data, bus.pop_valid, bus.count, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
    n_cmp++;
    if (bus.pop_data !== 8'h55 || bus.count !== '0) begin
      n_err++;
      $display("FAIL full_pp_last: data=%h cnt=%0d, expected 55 0", bus.pop_data, bus.count);
    end
    cycle(1'b0, '0, 1'b0);
  endtask

  task automatic test_underflow();
    logic [WIDTH-1:0] prev;
    prev = bus.pop_data;
    cycle(1'b0, '0, 1'b1);
    n_cmp++;
    if (bus.underflow !== 1'b1 || bus.pop_valid !== 1'b0 || bus.count !== '0 || bus.pop_data !== prev) begin
      n_err++;
      $display("FAIL underflow: un=%b v=%b cnt=%0d data=%h, expected 1 0 0 %h",
               bus.underflow, bus.pop_valid, bus.count, bus.pop_data, prev);
    end
    cycle(1'b1, 8'h40, 1'b0);
    for (int i = 1; i < 9; i++) cycle(1'b1, WIDTH'(8'h40 + i), 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    n_cmp++;
    if (bus.underflow !== 1'b1 || bus.count !== '0) begin
      n_err++;
      $display("FAIL underflow_stream: un=%b cnt=%0d, expected 1 0", bus.underflow, bus.count);
    end
  endtask

  task automatic test_empty_push_pop();
    apply_reset(1'b0);
    cycle(1'b1, 8'h77, 1'b1);
`ifdef ALIGN_FIFO_BYPASS_EN
    n_cmp++;
    if (bus.pop_valid !== 1'b1 || bus.pop_data !== 8'h77 || bus.count !== '0 || bus.underflow !== 1'b0) begin
      n_err++;
      $display("FAIL bypass: v=%b data=%h cnt=%0d un=%b, expected 1 77 0 0",
               bus.pop_valid, bus.pop_data, bus.count, bus.underflow);
    end
`else
    n_cmp++;
    if (bus.pop_valid !== 1'b0 || bus.count !== CW'(1) || bus.underflow !== 1'b1) begin
      n_err++;
      $display("FAIL empty_pp: v=%b cnt=%0d un=%b, expected 0 1 1",
               bus.pop_valid, bus.count, bus.underflow);
    end
    cycle(1'b0, '0, 1'b1);
    n_cmp++;
    if (bus.pop_valid !== 1'b1 || bus.pop_data !== 8'h77) begin
      n_err++;
      $display("FAIL empty_pp_pop: v=%b data=%h, expected 1 77", bus.pop_valid, bus.pop_data);
    end
`endif
    cycle(1'b0, '0, 1'b0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'(8'hC0 + i), 1'b0);
    apply_reset(1'b1);
    n_cmp++;
    if (bus.count !== '0 || bus.empty !== 1'b1 || bus.pop_valid !== 1'b0 || bus.pop_data !== '0 ||
        bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: cnt=%0d e=%b v=%b data=%h ov=%b un=%b, expected 0 1 0 00 0 0",
               bus.count, bus.empty, bus.pop_valid, bus.pop_data, bus.overflow, bus.underflow);
    end
    cycle(1'b1, 8'h99, 1'b0);
    cycle(1'b0, '0, 1'b1);
    n_cmp++;
    if (bus.pop_valid !== 1'b1 || bus.pop_data !== 8'h99) begin
      n_err++;
      $display("FAIL mid_reset_pop: v=%b data=%h, expected 1 99", bus.pop_valid, bus.pop_data);
    end
    cycle(1'b0, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    apply_reset(1'b0);
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      n_cmp++;
      if (bus.count !== CW'(model_q.size()) || bus.overflow !== m_over || bus.underflow !== m_under ||
          bus.full !== (model_q.size() == DEPTH) || bus.empty !== (model_q.size() == 0)) begin
        n_err++;
        $display("FAIL random_state: cnt=%0d ov=%b un=%b f=%b e=%b, expected cnt=%0d ov=%b un=%b",
                 bus.count, bus.overflow, bus.underflow, bus.full, bus.empty,
                 model_q.size(), m_over, m_under);
      end
    end
    while (model_q.size() != 0) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_over = 1'b0;
    m_under = 1'b0;
    bus.push = 1'b0;
    bus.push_data = '0;
    bus.pop = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    apply_reset(1'b0);
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_empty_push_pop();
    test_mid_reset();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d outputs never produced, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/align_fifo.md
Name: align_fifo

Overview:
Latency-matching sideband store that complements the fixed delay line.
- Sideband/tag data is pushed when an operand enters a variable- or long-latency pipeline.
- The same data is released in order when the pipeline's result-valid strobe arrives at the far end.
- Replaces long delay chains where pipeline latency is not constant, and re-aligns tags with results.
- Registered output, one-cycle read latency, sticky error flags for protocol violations.

Parameters:
WIDTH, 8, sideband data width in bits
DEPTH, 16, number of entries; power of two, >= 2

Ports:
clk  input  1  clock
reset  input  1  reset
push  input  1  write strobe, pipeline entry side
push_data  input  WIDTH  data written on push
pop  input  1  read strobe, driven by pipeline result-valid
pop_data  output  WIDTH  registered data released by pop
pop_valid  output  1  high one cycle after an accepted pop
count  output  $clog2(DEPTH+1)  current occupancy
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky: push rejected because full
underflow  output  1  sticky: pop rejected because empty

Behaviour:
- Reset (already decided): reset reset, synchronous, active-high; clock clk.
- Reset values: pop_data = 0, pop_valid = 0, count = 0, empty = 1, full = 0, overflow = 0, underflow = 0. Read and write pointers = 0. Memory contents are not cleared.
- Reset has priority over push and pop in the same cycle. Reset mid-operation discards all entries, and no pop_valid is issued for them.
- Storage: DEPTH x WIDTH array; write pointer wp, read pointer rp, each $clog2(DEPTH) bits. Pointers wrap modulo DEPTH (natural binary wrap).
- Occupancy: count is an explicit counter, not derived from pointers.
  - count updates +1 on accepted push only.
  - count updates -1 on accepted pop only.
  - count is unchanged on accepted push plus accepted pop in the same cycle.
- full and empty are combinational decodes of count.
- Push accept: push && (!full || pop_acc). Writes mem[wp] <= push_data, then wp++.
- Push on full with pop in the same cycle: both are accepted, and the oldest entry is read before the overwrite slot is reused.
- Push on full with no pop: data is discarded, wp and count are unchanged, overflow <= 1.
- Pop accept: pop_acc = pop && !empty, evaluated on pre-cycle occupancy.
  - On accept: pop_data <= mem[rp], rp++, pop_valid <= 1 in the next cycle.
- Pop on empty: rejected, underflow <= 1, pop_valid <= 0, pop_data holds its previous value.
  - This applies even with a simultaneous push, unless ALIGN_FIFO_BYPASS_EN is defined.
- pop_valid is 0 in any cycle not following an accepted pop. pop_data holds its last value between pops.
- Latency: push to earliest possible pop acceptance is 1 cycle (entry visible the cycle after the write). Pop to pop_data/pop_valid is 1 cycle.
- Throughput: one push and one pop per cycle, sustained.
- overflow and underflow are cleared only by reset.

Optional Feature:
ALIGN_FIFO_BYPASS_EN
- Defined: when empty && push && pop in the same cycle, the FIFO bypasses storage.
  - pop_data <= push_data, pop_valid <= 1.
  - Pointers, count and memory are unchanged.
  - underflow is not set.
  - This supports zero-latency pipelines where result-valid coincides with entry.
- Not defined: that case sets underflow. The push is still stored (count becomes 1) and pop_valid stays 0.

Test Plan:
1. Reset, then push 0x11, 0x22, 0x33 on consecutive cycles; pop three cycles later, 1/cycle -> pop_data 0x11, 0x22, 0x33 with pop_valid high 3 consecutive cycles; count 0,1,2,3,2,1,0; empty ends at 1.
2. Fill DEPTH=16 with 0x00..0x0F, then push 0xAA without pop -> full = 1, overflow = 1, count stays 16. Drain 16 pops -> 0x00..0x0F, 0xAA never appears.
3. Full, then push 0x55 with pop in the same cycle -> pop_data 0x00, count stays 16. After draining, the last value is 0x55. Wrap-around is exercised with no corruption.
4. Empty, then pop alone -> underflow = 1, pop_valid = 0, count 0, pop_data unchanged. Then push/pop streaming -> normal operation continues, underflow stays 1.
5. Empty with push 0x77 and pop in the same cycle. Without the macro -> underflow = 1, count = 1, next pop returns 0x77. With ALIGN_FIFO_BYPASS_EN -> pop_data 0x77, pop_valid = 1 next cycle, count 0, underflow 0.
6. Push 5 entries, assert reset together with pop -> next cycle count 0, empty 1, pop_valid 0, pop_data 0, flags 0. Then push 0x99 and pop -> 0x99 returned.
